// File: rtl/ahbl_pkg.sv
// rtl/ahbl_pkg.sv - shared AHB-Lite encodings, error-state enum and lane helpers
// Purpose: constants and small helpers used by the AHB-Lite memory controller.
// Ports: none (package).
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ERR1 = 2'd1;
  localparam logic [1:0] S_ERR2 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_ERR1 = S_ERR1,
    ST_ERR2 = S_ERR2
  } err_state_t;

  // Oversized, or not naturally aligned for its size.
  function automatic logic size_error(input logic [2:0] size, input logic [1:0] off);
    return (size > HSIZE_WORD) ||
           ((size == HSIZE_HALF) && off[0]) ||
           ((size == HSIZE_WORD) && (off != 2'b00));
  endfunction

  // Returns a bank enable mask, bit b = bank b (bank 0 holds data bits [31:24]).
  // Little-endian offset k maps to bank 3-k; big-endian offset k maps to bank k.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off,
                                           input logic little);
    logic [3:0] by_off;
    case (size)
      HSIZE_BYTE: by_off = 4'b0001 << off;
      HSIZE_HALF: by_off = 4'b0011 << off;
      default:    by_off = 4'b1111;
    endcase
    return little ? {by_off[0], by_off[1], by_off[2], by_off[3]} : by_off;
  endfunction

endpackage

// File: rtl/ahbl_mem_bank.sv
// rtl/ahbl_mem_bank.sv - one byte-lane RAM bank with asynchronous read
// Purpose: 8-bit wide storage bank, 2^IDX_W entries; array "mem" is the backdoor preload point.
// Ports:
//   clk   - clock, writes occur on the rising edge
//   we    - write enable
//   idx   - word index, shared by read and write
//   wdata - write byte
//   rdata - read byte, combinational from mem[idx]
module ahbl_mem_bank #(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [0:(1<<IDX_W)-1];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_lite_mem_ctrl.sv
// rtl/ahb_lite_mem_ctrl.sv - zero-wait-state AHB-Lite slave memory with byte-lane banks
// Purpose: word-organised RAM in four byte-lane banks, byte/half/word access, LE/BE lane order,
//          two-cycle ERROR response for misaligned or oversized transfers.
// Ports:
//   pll_core_cpuclk  - clock
//   pad_cpu_rst      - asynchronous active-high reset
//   lite_mmc_hsel    - slave select
//   lite_yy_haddr    - byte address
//   lite_yy_hsize    - transfer size
//   lite_yy_htrans   - transfer type
//   lite_yy_hwrite   - 1 = write
//   lite_yy_hwdata   - write data (data phase)
//   mmc_lite_hrdata  - read data, zero outside a read data phase
//   mmc_lite_hready  - slave ready
//   mmc_lite_hresp   - response
//   pad_biu_bigend_b - 1 = little-endian lane order, 0 = big-endian
module ahb_lite_mem_ctrl
  import ahbl_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic        pll_core_cpuclk,
  input  logic        pad_cpu_rst,
  input  logic        lite_mmc_hsel,
  input  logic [31:0] lite_yy_haddr,
  input  logic [2:0]  lite_yy_hsize,
  input  logic [1:0]  lite_yy_htrans,
  input  logic        lite_yy_hwrite,
  input  logic [31:0] lite_yy_hwdata,
  output logic [31:0] mmc_lite_hrdata,
  output logic        mmc_lite_hready,
  output logic [1:0]  mmc_lite_hresp,
  input  logic        pad_biu_bigend_b
);

  localparam int IDX_W = ADDR_W - 2;

  err_state_t       state, state_nxt;
  logic             addr_valid;
  logic             addr_err;
  logic             dp_active;
  logic             dp_write;
  logic [3:0]       dp_lanes;
  logic [IDX_W-1:0] dp_idx;
  logic [3:0]       bank_we;
  logic [7:0]       rd0, rd1, rd2, rd3;
  logic             unused_bits;

  // Address bits above ADDR_W alias; htrans[0] only distinguishes SEQ from NONSEQ.
  assign unused_bits = ^{lite_yy_haddr >> ADDR_W, lite_yy_htrans[0]};

  // hready is low only in ERR1, so the address phase there is ignored.
  assign addr_valid = lite_mmc_hsel & lite_yy_htrans[1] & mmc_lite_hready;
  assign addr_err   = size_error(lite_yy_hsize, lite_yy_haddr[1:0]);

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = (addr_valid && addr_err) ? ST_ERR1 : ST_IDLE;
    endcase
  end

  // Size and offset are folded into a lane mask at address time; the endian strap is
  // quasi-static, so sampling it here is equivalent to using it in the data phase.
  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      state     <= ST_IDLE;
      dp_active <= 1'b0;
      dp_write  <= 1'b0;
      dp_lanes  <= 4'b0000;
      dp_idx    <= '0;
    end else begin
      state     <= state_nxt;
      dp_active <= addr_valid & ~addr_err;
      if (addr_valid) begin
        dp_write <= lite_yy_hwrite;
        dp_lanes <= lane_mask(lite_yy_hsize, lite_yy_haddr[1:0], pad_biu_bigend_b);
        dp_idx   <= lite_yy_haddr[ADDR_W-1:2];
      end
    end
  end

  // Reset clears dp_active asynchronously, so a write whose data phase is hit by reset never lands.
  assign bank_we = {4{dp_active & dp_write}} & dp_lanes;

  ahbl_mem_bank #(.IDX_W(IDX_W)) ram0 (
    .clk(pll_core_cpuclk), .we(bank_we[0]), .idx(dp_idx),
    .wdata(lite_yy_hwdata[31:24]), .rdata(rd0)
  );
  ahbl_mem_bank #(.IDX_W(IDX_W)) ram1 (
    .clk(pll_core_cpuclk), .we(bank_we[1]), .idx(dp_idx),
    .wdata(lite_yy_hwdata[23:16]), .rdata(rd1)
  );
  ahbl_mem_bank #(.IDX_W(IDX_W)) ram2 (
    .clk(pll_core_cpuclk), .we(bank_we[2]), .idx(dp_idx),
    .wdata(lite_yy_hwdata[15:8]), .rdata(rd2)
  );
  ahbl_mem_bank #(.IDX_W(IDX_W)) ram3 (
    .clk(pll_core_cpuclk), .we(bank_we[3]), .idx(dp_idx),
    .wdata(lite_yy_hwdata[7:0]), .rdata(rd3)
  );

  assign mmc_lite_hrdata = (dp_active & ~dp_write) ? {rd0, rd1, rd2, rd3} : 32'h0;
  assign mmc_lite_hready = (state != ST_ERR1);
  assign mmc_lite_hresp  = (state == ST_IDLE) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: tb/tb_ahb_lite_mem_ctrl.sv
// tb/tb_ahb_lite_mem_ctrl.sv - scoreboard bench for ahb_lite_mem_ctrl
module tb_ahb_lite_mem_ctrl;
  import ahbl_pkg::*;

  localparam int ADDR_W = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;
  logic        bigend_b;

  ahb_lite_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst     (rst),
    .lite_mmc_hsel   (hsel),
    .lite_yy_haddr   (haddr),
    .lite_yy_hsize   (hsize),
    .lite_yy_htrans  (htrans),
    .lite_yy_hwrite  (hwrite),
    .lite_yy_hwdata  (hwdata),
    .mmc_lite_hrdata (hrdata),
    .mmc_lite_hready (hready),
    .mmc_lite_hresp  (hresp),
    .pad_biu_bigend_b(bigend_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  int          q_cyc[$];
  logic [34:0] q_val[$];
  string       q_name[$];

  task automatic push_exp(input logic rdy, input logic [1:0] resp, input logic [31:0] rdata,
                          input string name);
    q_cyc.push_back(cyc + 1);
    q_val.push_back({rdy, resp, rdata});
    q_name.push_back(name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one address phase (plus hwdata for the previous one) and expect the next cycle's outputs.
  task automatic op(input logic sel, input logic [1:0] trans, input logic wr,
                    input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata,
                    input logic rdy, input logic [1:0] resp, input logic [31:0] rdata,
                    input string name);
    hsel   = sel;
    htrans = trans;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
    hwdata = wdata;
    push_exp(rdy, resp, rdata, name);
    step();
  endtask

  task automatic idle(input logic [31:0] wdata, input logic rdy, input logic [1:0] resp,
                      input string name);
    op(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_BYTE, wdata, rdy, resp, 32'h0, name);
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: compares DUT outputs against whatever the scoreboard holds for this cycle.
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      int          c;
      logic [34:0] e;
      string       n;
      c = q_cyc.pop_front();
      e = q_val.pop_front();
      n = q_name.pop_front();
      tests++;
      if (c != cyc) begin
        fails++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", n, c, cyc);
      end else if ({hready, hresp, hrdata} !== e) begin
        fails++;
        $display("FAIL %s: hready=%0b hresp=%0d hrdata=%h, expected hready=%0b hresp=%0d hrdata=%h",
                 n, hready, hresp, hrdata, e[34], e[33:32], e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", q_cyc.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    hsel     = 1'b0;
    htrans   = HTRANS_IDLE;
    hwrite   = 1'b0;
    haddr    = 32'h0;
    hsize    = HSIZE_BYTE;
    hwdata   = 32'h0;
    bigend_b = 1'b1;

    // Backdoor preload: bank 0 is the most significant byte of the word.
    dut.ram0.mem[4]  = 8'h12; dut.ram1.mem[4]  = 8'h34; dut.ram2.mem[4]  = 8'h56; dut.ram3.mem[4]  = 8'h78;
    dut.ram0.mem[8]  = 8'h11; dut.ram1.mem[8]  = 8'h22; dut.ram2.mem[8]  = 8'h33; dut.ram3.mem[8]  = 8'h44;
    dut.ram0.mem[12] = 8'hA1; dut.ram1.mem[12] = 8'hA2; dut.ram2.mem[12] = 8'hA3; dut.ram3.mem[12] = 8'hA4;
    dut.ram0.mem[16] = 8'h01; dut.ram1.mem[16] = 8'h02; dut.ram2.mem[16] = 8'h03; dut.ram3.mem[16] = 8'h04;

    step();
    // Reset state, with a read request presented that must be ignored.
    op(1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b1, HRESP_OKAY, 32'h0, "reset_state_a");
    idle(32'h0, 1'b1, HRESP_OKAY, "reset_state_b");
    rst = 1'b0;
    idle(32'h0, 1'b1, HRESP_OKAY, "post_reset_idle");

    // Preloaded word read, little-endian.
    op(1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b1, HRESP_OKAY, 32'h12345678, "le_word_read");
    idle(32'h0, 1'b1, HRESP_OKAY, "idle_after_read");

    // LE byte write at offset 1 lands on bits [15:8].
    op(1'b1, HTRANS_NONSEQ, 1'b1, 32'h21, HSIZE_BYTE, 32'h0, 1'b1, HRESP_OKAY, 32'h0, "le_byte_wr_dp");
    op(1'b1, HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD, 32'h0000AB00, 1'b1, HRESP_OKAY, 32'h1122AB44, "le_byte_write");
    // LE halfword write at offset 2 lands on bits [31:16].
    op(1'b1, HTRANS_NONSEQ, 1'b1, 32'h22, HSIZE_HALF, 32'h0, 1'b1, HRESP_OKAY, 32'h0, "le_half_wr_dp");
    op(1'b1, HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD, 32'hCAFE0000, 1'b1, HRESP_OKAY, 32'hCAFEAB44, "le_half_write");
    idle(32'h0, 1'b1, HRESP_OKAY, "idle_after_le");

    // Big-endian halfword at offset 2 -> banks 2 and 3.
    bigend_b = 1'b0;
    op(1'b1, HTRANS_NONSEQ, 1'b1, 32'h32, HSIZE_HALF, 32'h0, 1'b1, HRESP_OKAY, 32'h0, "be_half_wr_dp");
    idle(32'h0000BEEF, 1'b1, HRESP_OKAY, "be_half_data");
    check8("be_half_ram0", dut.ram0.mem[12], 8'hA1);
    check8("be_half_ram1", dut.ram1.mem[12], 8'hA2);
    check8("be_half_ram2", dut.ram2.mem[12], 8'hBE);
    check8("be_half_ram3", dut.ram3.mem[12], 8'hEF);
    // Big-endian byte at offset 1 -> bank 1 (bits [23:16]).
    op(1'b1, HTRANS_NONSEQ, 1'b1, 32'h31, HSIZE_BYTE, 32'h0, 1'b1, HRESP_OKAY, 32'h0, "be_byte_wr_dp");
    op(1'b1, HTRANS_NONSEQ, 1'b0, 32'h30, HSIZE_WORD, 32'h00CC0000, 1'b1, HRESP_OKAY, 32'hA1CCBEEF, "be_byte_write");
    idle(32'h0, 1'b1, HRESP_OKAY, "idle_after_be");
    bigend_b = 1'b1;

    // Back-to-back write then read of the same word, no stall.
    op(1'b1, HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_WORD, 32'h0, 1'b1, HRESP_OKAY, 32'h0, "b2b_write_dp");
    op(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'hDEADBEEF, 1'b1, HRESP_OKAY, 32'hDEADBEEF, "b2b_read");
    idle(32'h0, 1'b1, HRESP_OKAY, "idle_after_b2b");

    // Misaligned word write: two-cycle ERROR, memory untouched.
    op(1'b1, HTRANS_NONSEQ, 1'b1, 32'h42, HSIZE_WORD, 32'h0, 1'b0, HRESP_ERROR, 32'h0, "misalign_err1");
    idle(32'h55555555, 1'b1, HRESP_ERROR, "misalign_err2");
    idle(32'h55555555, 1'b1, HRESP_OKAY, "misalign_done");
    op(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'h0, 1'b1, HRESP_OKAY, 32'hDEADBEEF, "misalign_unchanged");
    idle(32'h0, 1'b1, HRESP_OKAY, "idle_after_misalign");

    // Oversized read; a new read accepted during ERR2 completes normally.
    op(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, 3'd3, 32'h0, 1'b0, HRESP_ERROR, 32'h0, "oversize_err1");
    idle(32'h0, 1'b1, HRESP_ERROR, "oversize_err2");
    op(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'h0, 1'b1, HRESP_OKAY, 32'hDEADBEEF, "read_in_err2");
    idle(32'h0, 1'b1, HRESP_OKAY, "idle_after_oversize");

    // Odd-address halfword write.
    op(1'b1, HTRANS_NONSEQ, 1'b1, 32'h41, HSIZE_HALF, 32'h0, 1'b0, HRESP_ERROR, 32'h0, "odd_half_err1");
    idle(32'h11111111, 1'b1, HRESP_ERROR, "odd_half_err2");
    idle(32'h11111111, 1'b1, HRESP_OKAY, "odd_half_done");

    // BUSY and unselected transfers start no data phase.
    op(1'b1, HTRANS_BUSY, 1'b1, 32'h40, HSIZE_WORD, 32'h0, 1'b1, HRESP_OKAY, 32'h0, "busy_ignored");
    op(1'b0, HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_WORD, 32'h0, 1'b1, HRESP_OKAY, 32'h0, "unsel_ignored");
    op(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'h0, 1'b1, HRESP_OKAY, 32'hDEADBEEF, "word_40_intact");
    idle(32'h0, 1'b1, HRESP_OKAY, "idle_before_rst");

    // Reset during a write data phase drops the write.
    op(1'b1, HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'h0, 1'b1, HRESP_OKAY, 32'h0, "rst_mid_dp");
    rst = 1'b1;
    idle(32'hFFFFFFFF, 1'b1, HRESP_OKAY, "rst_mid_state");
    rst = 1'b0;
    check8("rst_mid_ram0", dut.ram0.mem[4], 8'h12);
    check8("rst_mid_ram3", dut.ram3.mem[4], 8'h78);
    op(1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b1, HRESP_OKAY, 32'h12345678, "preload_intact");
    idle(32'h0, 1'b1, HRESP_OKAY, "final_idle");

    step();
    step();
    tests++;
    if (q_cyc.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q_cyc.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
